intensity_window_ctrl: RTL and testbench

//   Sequences the audio-intensity datapath: accepts signed audio samples over a

---
 rtl/intensity_window_ctrl.sv | 156 +++++++++++++++
 tb/tb_intensity_window_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intensity_window_ctrl.sv
// Audio-intensity window controller: averages sample magnitudes over 2**LOG2_WINDOW accepts.
// Optional peak-hold output enabled by defining PEAK_HOLD_EN.
module intensity_window_ctrl #(
    parameter int DATA_W      = 8,
    parameter int LOG2_WINDOW = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              sample_ready,
    output logic [DATA_W-1:0] level,
    output logic              level_valid,
    output logic              busy
`ifdef PEAK_HOLD_EN
    ,
    output logic [DATA_W-1:0] peak
`endif
);

    localparam int SUM_W  = DATA_W + LOG2_WINDOW;
    localparam int CNT_W  = LOG2_WINDOW + 1;
    localparam int WINDOW = 1 << LOG2_WINDOW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        AVERAGE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  level_q, level_d;
    logic               levelValid_q, levelValid_d;
    logic [DATA_W-1:0]  magnitude;
    logic               accept;
    logic               lastAccept;

    // Most-negative input has no positive twin, so it saturates to the max positive value.
    always_comb begin
        if (sample == {1'b1, {(DATA_W-1){1'b0}}}) begin
            magnitude = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sample[DATA_W-1]) begin
            magnitude = -sample;
        end else begin
            magnitude = sample;
        end
    end

    assign accept     = sample_valid & sample_ready;
    assign lastAccept = accept && (count_q == CNT_W'(WINDOW - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = ACCUM;
            ACCUM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (lastAccept) begin
                    state_d = AVERAGE;
                end
            end
            AVERAGE: state_d = enable ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_ready = (state_q == ACCUM);
        busy         = (count_q != '0);
    end

    // Aborting in ACCUM drops the partial window; level keeps its last published value.
    always_comb begin
        sum_d        = sum_q;
        count_d      = count_q;
        level_d      = level_q;
        levelValid_d = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (!enable) begin
                    sum_d   = '0;
                    count_d = '0;
                end else if (accept) begin
                    sum_d   = sum_q + {{LOG2_WINDOW{1'b0}}, magnitude};
                    count_d = count_q + CNT_W'(1);
                end
            end
            AVERAGE: begin
                level_d      = sum_q[SUM_W-1:LOG2_WINDOW];
                levelValid_d = 1'b1;
                sum_d        = '0;
                count_d      = '0;
            end
            default: begin
                sum_d   = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum_q        <= '0;
            count_q      <= '0;
            level_q      <= '0;
            levelValid_q <= 1'b0;
        end else begin
            sum_q        <= sum_d;
            count_q      <= count_d;
            level_q      <= level_d;
            levelValid_q <= levelValid_d;
        end
    end

    assign level       = level_q;
    assign level_valid = levelValid_q;

`ifdef PEAK_HOLD_EN
    logic [DATA_W-1:0] peak_q, peak_d;

    // Peak decays by one per publish unless the new level beats it.
    always_comb begin
        peak_d = peak_q;
        if (state_q == AVERAGE) begin
            if (level_d > peak_q) begin
                peak_d = level_d;
            end else if (peak_q != '0) begin
                peak_d = peak_q - DATA_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

endmodule

// File: tb/tb_intensity_window_ctrl.sv
// Self-checking bench for intensity_window_ctrl: directed scenarios plus randomized traffic
// compared against a window-queue reference model. Peak checks active when PEAK_HOLD_EN is defined.
module tb_intensity_window_ctrl;

    localparam int DATA_W      = 8;
    localparam int LOG2_WINDOW = 3;
    localparam int WINDOW      = 1 << LOG2_WINDOW;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              sample_ready;
    logic [DATA_W-1:0] level;
    logic              level_valid;
    logic              busy;
`ifdef PEAK_HOLD_EN
    logic [DATA_W-1:0] peak;
`endif

    intensity_window_ctrl #(
        .DATA_W      (DATA_W),
        .LOG2_WINDOW (LOG2_WINDOW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_ready (sample_ready),
        .level        (level),
        .level_valid  (level_valid),
        .busy         (busy)
`ifdef PEAK_HOLD_EN
        ,
        .peak         (peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 publishing; window contents kept as a queue.
    int mPhase = 0;
    int mWin[$];
    int mLevel = 0;
    int mValid = 0;
    int mPeak  = 0;
    int mAccepted = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int magOf(input logic [DATA_W-1:0] s);
        int x;
        x = int'($signed(s));
        if (x < 0) x = -x;
        if (x > 127) x = 127;
        return x;
    endfunction

    task automatic modelEdge(input logic rst, input logic en, input logic v, input logic [DATA_W-1:0] s);
        int total;
        mAccepted = 0;
        if (!rst) begin
            mPhase = 0;
            mWin.delete();
            mLevel = 0;
            mValid = 0;
            mPeak  = 0;
            return;
        end
        mValid = 0;
        case (mPhase)
            0: if (en) mPhase = 1;
            1: begin
                if (!en) begin
                    mWin.delete();
                    mPhase = 0;
                end else if (v) begin
                    mAccepted = 1;
                    mWin.push_back(magOf(s));
                    if (mWin.size() == WINDOW) mPhase = 2;
                end
            end
            default: begin
                total = 0;
                foreach (mWin[i]) total += mWin[i];
                mLevel = total / WINDOW;
                mValid = 1;
                if (mLevel > mPeak) mPeak = mLevel;
                else if (mPeak > 0) mPeak = mPeak - 1;
                mWin.delete();
                mPhase = en ? 1 : 0;
            end
        endcase
    endtask

    // One clock cycle: drive inputs, check pre-edge handshake outputs, then post-edge results.
    task automatic applyStimulus(input logic rst, input logic en, input logic v, input logic [DATA_W-1:0] s);
        @(negedge clk);
        reset_n      = rst;
        enable       = en;
        sample_valid = v;
        sample       = s;
        #1;
        checkOutput("sample_ready", {31'd0, sample_ready}, (mPhase == 1) ? 32'd1 : 32'd0);
        checkOutput("busy", {31'd0, busy}, (mWin.size() != 0) ? 32'd1 : 32'd0);
        @(posedge clk);
        modelEdge(rst, en, v, s);
        #1;
        checkOutput("level", {24'd0, level}, mLevel);
        checkOutput("level_valid", {31'd0, level_valid}, mValid);
`ifdef PEAK_HOLD_EN
        checkOutput("peak", {24'd0, peak}, mPeak);
`endif
    endtask

    // Offer a sample every 'gap' cycles until n of them have been accepted.
    task automatic feed(input logic [DATA_W-1:0] v, input int n, input int gap);
        int got = 0;
        int cyc = 0;
        while (got < n) begin
            applyStimulus(1'b1, 1'b1, (cyc % gap) == 0, v);
            if (mAccepted != 0) got++;
            cyc++;
            if (cyc > 500) begin
                checkOutput("feed_timeout", cyc, 0);
                return;
            end
        end
    endtask

    task automatic publish();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        repeat (2) @(posedge clk);
        #1;
        modelEdge(1'b0, 1'b0, 1'b0, '0);
        checkOutput("rst_level", {24'd0, level}, 0);
        checkOutput("rst_level_valid", {31'd0, level_valid}, 0);
        checkOutput("rst_ready", {31'd0, sample_ready}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
`ifdef PEAK_HOLD_EN
        checkOutput("rst_peak", {24'd0, peak}, 0);
`endif

        // Back-to-back window of 16s.
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        feed(8'd16, 8, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd16);
        checkOutput("t1_level", {24'd0, level}, 16);
        checkOutput("t1_pulse", {31'd0, level_valid}, 1);

        // Alternating +10/-10, then zeros.
        for (int i = 0; i < 8; i++) feed((i % 2) ? 8'hF6 : 8'd10, 1, 1);
        publish();
        checkOutput("t2_level10", {24'd0, level}, 10);
        feed(8'd0, 8, 1);
        publish();
        checkOutput("t2_level0", {24'd0, level}, 0);

        // Saturating magnitude.
        feed(8'h80, 8, 1);
        publish();
        checkOutput("t3_neg_sat", {24'd0, level}, 127);
        feed(8'd127, 8, 1);
        publish();
        checkOutput("t3_pos_max", {24'd0, level}, 127);

        // Aborted window, then clean window of 4s.
        feed(8'd50, 5, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("t4_idle_busy", {31'd0, busy}, 0);
        checkOutput("t4_hold_level", {24'd0, level}, 127);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        feed(8'd4, 8, 1);
        publish();
        checkOutput("t4_level", {24'd0, level}, 4);

        // Sparse valid, then reset mid-window.
        feed(8'd20, 8, 3);
        publish();
        checkOutput("t5_level", {24'd0, level}, 20);
        feed(8'd30, 3, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd30);
        checkOutput("t5_rst_level", {24'd0, level}, 0);
        checkOutput("t5_rst_ready", {31'd0, sample_ready}, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        feed(8'd20, 8, 1);
        publish();
        checkOutput("t5_restart_level", {24'd0, level}, 20);

        // Peak-hold sequence from a clean reset.
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        feed(8'd40, 8, 1); publish();
`ifdef PEAK_HOLD_EN
        checkOutput("t6_peak40", {24'd0, peak}, 40);
`endif
        feed(8'd10, 8, 1); publish();
`ifdef PEAK_HOLD_EN
        checkOutput("t6_peak39", {24'd0, peak}, 39);
`endif
        feed(8'd10, 8, 1); publish();
`ifdef PEAK_HOLD_EN
        checkOutput("t6_peak38", {24'd0, peak}, 38);
`endif
        feed(8'd60, 8, 1); publish();
`ifdef PEAK_HOLD_EN
        checkOutput("t6_peak60", {24'd0, peak}, 60);
`endif
        checkOutput("t6_level", {24'd0, level}, 60);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            logic rr, ee, vv;
            logic [DATA_W-1:0] ss;
            rr = ($urandom_range(0, 199) != 0);
            ee = ($urandom_range(0, 29) != 0);
            vv = ($urandom_range(0, 9) < 7);
            ss = ($urandom_range(0, 7) == 0) ? 8'h80 : DATA_W'($urandom);
            applyStimulus(rr, ee, vv, ss);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
